id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage. It holds the IF/ID pipeline register, the 32×32 register file and the load-use/branch hazard unit, and it resolves beq and j. It drives IF's `Branch`, `Jump`, `JumpAddr` and `IFWrite` inputs and presents decoded operands and controls to the EX stage, whose ID/EX register is outside this block.

---
 rtl/id_stage.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : instruction-decode stage of the 5-stage MIPS pipeline.
//
// Holds the IF/ID pipeline register, the 32x32 register file and the
// load-use / branch hazard unit. beq and j are resolved here, so the stage
// drives the redirect (Branch/Jump/JumpAddr) and the stall (IFWrite) back to
// IF. Decoded operands and controls go to the EX stage.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   Instruction_if, PC          instruction fetched by IF and its address
//   IF_flush                    squash the instruction being latched into IF/ID
//   MemRead_ex, RegWrite_ex,
//   RegWriteAddr_ex             producer currently in EX
//   RegWrite_mem,
//   RegWriteAddr_mem            producer currently in MEM
//   RegWrite_wb, RegWriteAddr_wb,
//   RegWriteData_wb             register-file write port from WB
//   IFWrite                     0 stalls IF and the IF/ID register
//   Branch, Jump, JumpAddr      taken beq / j and their common target
//   ReadData1_id, ReadData2_id  rs / rt operand values
//   Imm_id                      sign-extended imm16
//   Rs_id, Rt_id, Rd_id         register specifiers
//   RegWrite_id .. ALUCode_id   EX/MEM/WB controls (ALUCode: 0 add, 1 sub,
//                               2 and, 3 or, 4 slt)
// -----------------------------------------------------------------------------
module id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction_if,
   input  logic [31:0] PC,
   input  logic        IF_flush,
   input  logic        MemRead_ex,
   input  logic        RegWrite_ex,
   input  logic [4:0]  RegWriteAddr_ex,
   input  logic        RegWrite_mem,
   input  logic [4:0]  RegWriteAddr_mem,
   input  logic        RegWrite_wb,
   input  logic [4:0]  RegWriteAddr_wb,
   input  logic [31:0] RegWriteData_wb,
   output logic        IFWrite,
   output logic        Branch,
   output logic        Jump,
   output logic [31:0] JumpAddr,
   output logic [31:0] ReadData1_id,
   output logic [31:0] ReadData2_id,
   output logic [31:0] Imm_id,
   output logic [4:0]  Rs_id,
   output logic [4:0]  Rt_id,
   output logic [4:0]  Rd_id,
   output logic        RegWrite_id,
   output logic        MemRead_id,
   output logic        MemWrite_id,
   output logic        MemtoReg_id,
   output logic        ALUSrc_id,
   output logic        RegDst_id,
   output logic [2:0]  ALUCode_id
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_SLT  = 3'd4;

   // IF/ID register and register file state
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q,    pc_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   // Decoded fields
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs, rt, rd;
   logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
   logic        uses_rt;

   // Hazard terms
   logic        load_use_hz;
   logic        branch_hz;
   logic        hazard;

   // Address arithmetic
   logic signed [31:0] imm_sext;
   logic [31:0]        pc_plus4;
   logic [31:0]        branch_target;
   logic [31:0]        jump_target;

   // Un-gated controls before the bubble is applied
   logic        ctl_regwrite, ctl_memread, ctl_memwrite;
   logic        ctl_memtoreg, ctl_alusrc, ctl_regdst;
   logic [2:0]  ctl_alucode;

   // --------------------------------------------------------------------------
   // IF/ID register next state: flush beats stall beats load.
   // --------------------------------------------------------------------------
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (IF_flush) begin
         instr_d = 32'h0000_0000;
         pc_d    = PC;
      end else if (!hazard) begin
         instr_d = Instruction_if;
         pc_d    = PC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= 32'h0000_0000;
         pc_q    <= 32'h0000_0000;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   // --------------------------------------------------------------------------
   // Register file. r0 is never written, so its flop stays at zero.
   // --------------------------------------------------------------------------
   always_comb begin
      regs_d = regs_q;
      if (RegWrite_wb && (RegWriteAddr_wb != 5'd0)) begin
         regs_d[RegWriteAddr_wb] = RegWriteData_wb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'h0000_0000;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Field extraction
   // --------------------------------------------------------------------------
   assign op       = instr_q[31:26];
   assign rs       = instr_q[25:21];
   assign rt       = instr_q[20:16];
   assign rd       = instr_q[15:11];
   assign funct    = instr_q[5:0];

   assign is_rtype = (op == OP_RTYPE);
   assign is_addi  = (op == OP_ADDI);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_j     = (op == OP_J);

   // Instructions that actually consume rt as a source operand.
   assign uses_rt  = is_rtype | is_sw | is_beq;

   // Combinational reads with WB write-through, so a value written this cycle
   // is visible to the instruction in ID without an extra bypass in EX.
   always_comb begin
      if (rs == 5'd0) begin
         ReadData1_id = 32'h0000_0000;
      end else if (RegWrite_wb && (RegWriteAddr_wb == rs)) begin
         ReadData1_id = RegWriteData_wb;
      end else begin
         ReadData1_id = regs_q[rs];
      end
   end

   always_comb begin
      if (rt == 5'd0) begin
         ReadData2_id = 32'h0000_0000;
      end else if (RegWrite_wb && (RegWriteAddr_wb == rt)) begin
         ReadData2_id = RegWriteData_wb;
      end else begin
         ReadData2_id = regs_q[rt];
      end
   end

   // --------------------------------------------------------------------------
   // Main decode. Unknown opcodes and functs leave everything at zero.
   // --------------------------------------------------------------------------
   always_comb begin
      ctl_regwrite = 1'b0;
      ctl_memread  = 1'b0;
      ctl_memwrite = 1'b0;
      ctl_memtoreg = 1'b0;
      ctl_alusrc   = 1'b0;
      ctl_regdst   = 1'b0;
      ctl_alucode  = ALU_ADD;
      if (is_rtype) begin
         case (funct)
            FN_ADD: begin ctl_regwrite = 1'b1; ctl_regdst = 1'b1; ctl_alucode = ALU_ADD; end
            FN_SUB: begin ctl_regwrite = 1'b1; ctl_regdst = 1'b1; ctl_alucode = ALU_SUB; end
            FN_AND: begin ctl_regwrite = 1'b1; ctl_regdst = 1'b1; ctl_alucode = ALU_AND; end
            FN_OR:  begin ctl_regwrite = 1'b1; ctl_regdst = 1'b1; ctl_alucode = ALU_OR;  end
            FN_SLT: begin ctl_regwrite = 1'b1; ctl_regdst = 1'b1; ctl_alucode = ALU_SLT; end
            default: ;
         endcase
      end else if (is_addi) begin
         ctl_regwrite = 1'b1;
         ctl_alusrc   = 1'b1;
      end else if (is_lw) begin
         ctl_regwrite = 1'b1;
         ctl_memread  = 1'b1;
         ctl_memtoreg = 1'b1;
         ctl_alusrc   = 1'b1;
      end else if (is_sw) begin
         ctl_memwrite = 1'b1;
         ctl_alusrc   = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Hazard unit
   // --------------------------------------------------------------------------
   // A load in EX cannot be forwarded in time to the instruction in ID.
   assign load_use_hz = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                        ((RegWriteAddr_ex == rs) ||
                         (uses_rt && (RegWriteAddr_ex == rt)));

   // beq compares in ID, so any in-flight producer in EX or MEM must drain to
   // WB first, where the write-through supplies the value.
   assign branch_hz = is_beq && (
                         (RegWrite_ex  && (RegWriteAddr_ex  != 5'd0) &&
                          ((RegWriteAddr_ex  == rs) || (RegWriteAddr_ex  == rt))) ||
                         (RegWrite_mem && (RegWriteAddr_mem != 5'd0) &&
                          ((RegWriteAddr_mem == rs) || (RegWriteAddr_mem == rt))));

   assign hazard  = load_use_hz | branch_hz;
   assign IFWrite = ~hazard;

   // --------------------------------------------------------------------------
   // Outputs to EX; a stall turns this instruction into a bubble by killing
   // every state-changing control.
   // --------------------------------------------------------------------------
   assign RegWrite_id = ctl_regwrite & ~hazard;
   assign MemRead_id  = ctl_memread  & ~hazard;
   assign MemWrite_id = ctl_memwrite & ~hazard;
   assign MemtoReg_id = ctl_memtoreg;
   assign ALUSrc_id   = ctl_alusrc;
   assign RegDst_id   = ctl_regdst;
   assign ALUCode_id  = ctl_alucode;

   assign Rs_id  = rs;
   assign Rt_id  = rt;
   assign Rd_id  = rd;

   assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
   assign Imm_id   = imm_sext;

   // --------------------------------------------------------------------------
   // Redirect
   // --------------------------------------------------------------------------
   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};

   assign Branch = is_beq & ~hazard & (ReadData1_id == ReadData2_id);
   assign Jump   = is_j   & ~hazard;

   always_comb begin
      if (is_beq) begin
         JumpAddr = branch_target;
      end else if (is_j) begin
         JumpAddr = jump_target;
      end else begin
         JumpAddr = pc_plus4;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage. Directed scenarios plus a
// randomized run checked against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_id_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] Instruction_if, PC;
   logic        IF_flush, MemRead_ex, RegWrite_ex;
   logic [4:0]  RegWriteAddr_ex;
   logic        RegWrite_mem;
   logic [4:0]  RegWriteAddr_mem;
   logic        RegWrite_wb;
   logic [4:0]  RegWriteAddr_wb;
   logic [31:0] RegWriteData_wb;

   logic        IFWrite, Branch, Jump;
   logic [31:0] JumpAddr, ReadData1_id, ReadData2_id, Imm_id;
   logic [4:0]  Rs_id, Rt_id, Rd_id;
   logic        RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id;
   logic [2:0]  ALUCode_id;

   id_stage dut (
      .clk(clk), .reset(reset),
      .Instruction_if(Instruction_if), .PC(PC), .IF_flush(IF_flush),
      .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
      .RegWrite_mem(RegWrite_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
      .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
      .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
      .ReadData1_id(ReadData1_id), .ReadData2_id(ReadData2_id), .Imm_id(Imm_id),
      .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id),
      .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
      .MemtoReg_id(MemtoReg_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
      .ALUCode_id(ALUCode_id)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: architectural registers and the IF/ID contents.
   logic [31:0] m_regs [32];
   logic [31:0] m_instr, m_pc;

   typedef struct packed {
      logic rw, mr, mw, m2r, as, rd;
      logic [2:0] alu;
   } ctl_t;

   function automatic ctl_t m_ctl(input logic [31:0] ins);
      ctl_t c;
      int   code;
      c = '0;
      code = -1;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20: code = 0;
               6'h22: code = 1;
               6'h24: code = 2;
               6'h25: code = 3;
               6'h2a: code = 4;
               default: code = -1;
            endcase
            if (code >= 0) begin c.rw = 1; c.rd = 1; c.alu = 3'(code); end
         end
         6'h08: begin c.rw = 1; c.as = 1; end
         6'h23: begin c.rw = 1; c.mr = 1; c.m2r = 1; c.as = 1; end
         6'h2b: begin c.mw = 1; c.as = 1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (RegWrite_wb && RegWriteAddr_wb == a) return RegWriteData_wb;
      return m_regs[a];
   endfunction

   function automatic logic m_hazard();
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic       lu, bh, src_rt;
      op = m_instr[31:26];
      rs = m_instr[25:21];
      rt = m_instr[20:16];
      src_rt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
      lu = MemRead_ex && RegWriteAddr_ex != 0 &&
           (RegWriteAddr_ex == rs || (src_rt && RegWriteAddr_ex == rt));
      bh = (op == 6'h04) &&
           ((RegWrite_ex  && RegWriteAddr_ex  != 0 && (RegWriteAddr_ex  == rs || RegWriteAddr_ex  == rt)) ||
            (RegWrite_mem && RegWriteAddr_mem != 0 && (RegWriteAddr_mem == rs || RegWriteAddr_mem == rt)));
      return lu || bh;
   endfunction

   function automatic logic [31:0] m_target();
      logic [31:0] pc4;
      int          off;
      pc4 = m_pc + 32'd4;
      if (m_instr[31:26] == 6'h04) begin
         off = $signed(m_instr[15:0]);
         off = off * 4;
         return pc4 + 32'(off);
      end
      if (m_instr[31:26] == 6'h02) return {pc4[31:28], m_instr[25:0], 2'b00};
      return pc4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_instr = 32'h0;
      m_pc    = 32'h0;
   endtask

   task automatic clear_inputs();
      IF_flush = 0; MemRead_ex = 0; RegWrite_ex = 0; RegWriteAddr_ex = 0;
      RegWrite_mem = 0; RegWriteAddr_mem = 0;
      RegWrite_wb = 0; RegWriteAddr_wb = 0; RegWriteData_wb = 0;
   endtask

   // Advance one clock, updating the model from the inputs seen before the edge.
   task automatic step();
      logic [31:0] ni, np;
      logic        hz, we;
      logic [4:0]  wa;
      logic [31:0] wd;
      hz = m_hazard();
      ni = m_instr; np = m_pc;
      if (IF_flush) begin ni = 32'h0; np = PC; end
      else if (!hz) begin ni = Instruction_if; np = PC; end
      we = RegWrite_wb; wa = RegWriteAddr_wb; wd = RegWriteData_wb;
      @(posedge clk); #1;
      m_instr = ni; m_pc = np;
      if (we && wa != 0) m_regs[wa] = wd;
   endtask

   task automatic load(input logic [31:0] ins, input logic [31:0] pc);
      clear_inputs();
      Instruction_if = ins; PC = pc;
      step();
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      clear_inputs();
      Instruction_if = 32'h0;
      RegWrite_wb = 1; RegWriteAddr_wb = a; RegWriteData_wb = d;
      step();
      RegWrite_wb = 0;
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      // state straight out of the initial reset
      #1;
      n_cmp++; if (JumpAddr !== 32'h4 || IFWrite !== 1'b1) begin n_bad++;
         $display("FAIL reset_init: JumpAddr=%h IFWrite=%b required 00000004/1", JumpAddr, IFWrite); end
      for (int i = 1; i < 32; i++) wb_write(5'(i), $urandom | 32'h1);
      // add r4,r2,r3 with a load to r2 in EX -> stalled
      load(32'h00432020, 32'h0000_0100);
      MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 5'd2;
      #1;
      n_cmp++; if (IFWrite !== 1'b0) begin n_bad++;
         $display("FAIL reset_pre_stall: IFWrite=%b required 0", IFWrite); end
      #1 reset = 1;
      #1;
      model_reset();
      n_cmp++; if (IFWrite !== 1'b1) begin n_bad++; $display("FAIL reset_ifwrite: got %b required 1", IFWrite); end
      n_cmp++; if (Branch !== 1'b0 || Jump !== 1'b0) begin n_bad++;
         $display("FAIL reset_redirect: Branch=%b Jump=%b required 0/0", Branch, Jump); end
      n_cmp++; if (RegWrite_id !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b required 0", RegWrite_id); end
      n_cmp++; if (JumpAddr !== 32'h4) begin n_bad++; $display("FAIL reset_jumpaddr: got %h required 00000004", JumpAddr); end
      clear_inputs();
      @(posedge clk); #1 reset = 0;
      for (int i = 1; i < 32; i++) begin
         load({6'd0, 5'(i), 5'(i), 5'd1, 5'd0, 6'h20}, 32'h0);
         #1;
         n_cmp++; if (ReadData1_id !== m_read(5'(i)) || ReadData2_id !== 32'h0) begin n_bad++;
            $display("FAIL reset_reg r%0d: got %h/%h required 0", i, ReadData1_id, ReadData2_id); end
      end
   endtask

   task automatic test_write_through();
      load(32'h00A01820, 32'h0000_0200);          // add r3,r5,r0
      RegWrite_wb = 1; RegWriteAddr_wb = 5'd5; RegWriteData_wb = 32'h0000_1234;
      #1;
      n_cmp++; if (ReadData1_id !== 32'h0000_1234) begin n_bad++;
         $display("FAIL write_through: got %h required 00001234", ReadData1_id); end
      step();
      RegWriteAddr_wb = 5'd0; RegWriteData_wb = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (ReadData2_id !== 32'h0) begin n_bad++;
         $display("FAIL r0_write_same_cycle: got %h required 0", ReadData2_id); end
      step();
      RegWrite_wb = 0;
      #1;
      n_cmp++; if (ReadData2_id !== 32'h0 || ReadData1_id !== 32'h0000_1234) begin n_bad++;
         $display("FAIL r0_after_write: r0=%h r5=%h required 0/00001234", ReadData2_id, ReadData1_id); end
   endtask

   task automatic test_load_use();
      load(32'h00432020, 32'h0000_0300);          // add r4,r2,r3
      Instruction_if = 32'hFFFF_FFFF;
      MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 5'd2;
      #1;
      n_cmp++; if (IFWrite !== 1'b0 || RegWrite_id !== 1'b0) begin n_bad++;
         $display("FAIL load_use_stall: IFWrite=%b RegWrite_id=%b required 0/0", IFWrite, RegWrite_id); end
      step();
      MemRead_ex = 0; RegWrite_ex = 0; RegWriteAddr_ex = 0;
      RegWrite_mem = 1; RegWriteAddr_mem = 5'd2;
      #1;
      n_cmp++; if (IFWrite !== 1'b1 || RegWrite_id !== 1'b1) begin n_bad++;
         $display("FAIL load_use_release: IFWrite=%b RegWrite_id=%b required 1/1", IFWrite, RegWrite_id); end
      n_cmp++; if (Rd_id !== 5'd4 || Rs_id !== 5'd2) begin n_bad++;
         $display("FAIL load_use_hold: rs=%0d rd=%0d required 2/4", Rs_id, Rd_id); end
   endtask

   task automatic test_beq_taken();
      load(32'h10210003, 32'h0000_0010);          // beq r1,r1,+3
      #1;
      n_cmp++; if (Branch !== 1'b1 || JumpAddr !== 32'h20) begin n_bad++;
         $display("FAIL beq_taken: Branch=%b JumpAddr=%h required 1/00000020", Branch, JumpAddr); end
      IF_flush = 1; Instruction_if = 32'h1234_5678; PC = 32'h20;
      step();
      IF_flush = 0;
      #1;
      n_cmp++; if (Branch !== 1'b0 || Rs_id !== 5'd0 || Imm_id !== 32'h0) begin n_bad++;
         $display("FAIL beq_flush: Branch=%b rs=%0d imm=%h required NOP", Branch, Rs_id, Imm_id); end
   endtask

   task automatic test_jump();
      load(32'h08000005, 32'h0000_0040);
      #1;
      n_cmp++; if (Jump !== 1'b1 || JumpAddr !== 32'h14) begin n_bad++;
         $display("FAIL jump: Jump=%b JumpAddr=%h required 1/00000014", Jump, JumpAddr); end
   endtask

   task automatic test_beq_after_alu();
      wb_write(5'd1, 32'd7);
      wb_write(5'd2, 32'd9);
      load(32'h10220002, 32'h0000_0100);          // beq r1,r2,+2
      RegWrite_ex = 1; RegWriteAddr_ex = 5'd1;
      #1;
      n_cmp++; if (Branch !== 1'b0 || IFWrite !== 1'b0) begin n_bad++;
         $display("FAIL beq_stall1: Branch=%b IFWrite=%b required 0/0", Branch, IFWrite); end
      step();
      RegWrite_ex = 0; RegWriteAddr_ex = 0; RegWrite_mem = 1; RegWriteAddr_mem = 5'd1;
      #1;
      n_cmp++; if (Branch !== 1'b0 || IFWrite !== 1'b0) begin n_bad++;
         $display("FAIL beq_stall2: Branch=%b IFWrite=%b required 0/0", Branch, IFWrite); end
      step();
      RegWrite_mem = 0; RegWriteAddr_mem = 0;
      RegWrite_wb = 1; RegWriteAddr_wb = 5'd1; RegWriteData_wb = 32'd9;
      #1;
      n_cmp++; if (Branch !== 1'b1 || IFWrite !== 1'b1 || JumpAddr !== 32'h10C) begin n_bad++;
         $display("FAIL beq_bypass: Branch=%b IFWrite=%b JumpAddr=%h required 1/1/0000010c", Branch, IFWrite, JumpAddr); end
      step();
      clear_inputs();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fn;
      logic [15:0] imm;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      case ($urandom_range(0, 5))
         0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
         3: fn = 6'h25; 4: fn = 6'h2a; default: fn = 6'($urandom);
      endcase
      case ($urandom_range(0, 7))
         0: return {6'h00, rs, rt, rd, 5'd0, fn};
         1: return {6'h08, rs, rt, imm};
         2: return {6'h23, rs, rt, imm};
         3: return {6'h2b, rs, rt, imm};
         4: return {6'h04, rs, rt, imm};
         5: return {6'h02, 26'($urandom)};
         6: return $urandom;
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_random();
      ctl_t        c;
      logic        hz, beq, jmp;
      logic [4:0]  rs, rt;
      for (int n = 0; n < 400; n++) begin
         Instruction_if   = rand_instr();
         PC               = $urandom & 32'hFFFF_FFFC;
         IF_flush         = ($urandom_range(0, 9) == 0);
         MemRead_ex       = ($urandom_range(0, 3) == 0);
         RegWrite_ex      = ($urandom_range(0, 2) == 0);
         RegWriteAddr_ex  = 5'($urandom_range(0, 3));
         RegWrite_mem     = ($urandom_range(0, 2) == 0);
         RegWriteAddr_mem = 5'($urandom_range(0, 3));
         RegWrite_wb      = ($urandom_range(0, 1) == 0);
         RegWriteAddr_wb  = 5'($urandom_range(0, 3));
         RegWriteData_wb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         #1;
         hz  = m_hazard();
         c   = m_ctl(m_instr);
         rs  = m_instr[25:21];
         rt  = m_instr[20:16];
         beq = (m_instr[31:26] == 6'h04);
         jmp = (m_instr[31:26] == 6'h02);
         if (hz) begin c.rw = 0; c.mr = 0; c.mw = 0; end
         n_cmp++; if (IFWrite !== !hz) begin n_bad++;
            $display("FAIL rnd_ifwrite #%0d: got %b required %b", n, IFWrite, !hz); end
         n_cmp++; if (Branch !== (beq && !hz && m_read(rs) == m_read(rt))) begin n_bad++;
            $display("FAIL rnd_branch #%0d: got %b instr=%h", n, Branch, m_instr); end
         n_cmp++; if (Jump !== (jmp && !hz)) begin n_bad++;
            $display("FAIL rnd_jump #%0d: got %b instr=%h", n, Jump, m_instr); end
         n_cmp++; if (JumpAddr !== m_target()) begin n_bad++;
            $display("FAIL rnd_jumpaddr #%0d: got %h required %h", n, JumpAddr, m_target()); end
         n_cmp++; if (ReadData1_id !== m_read(rs) || ReadData2_id !== m_read(rt)) begin n_bad++;
            $display("FAIL rnd_read #%0d: got %h/%h required %h/%h", n, ReadData1_id, ReadData2_id, m_read(rs), m_read(rt)); end
         n_cmp++; if (Imm_id !== {{16{m_instr[15]}}, m_instr[15:0]}) begin n_bad++;
            $display("FAIL rnd_imm #%0d: got %h instr=%h", n, Imm_id, m_instr); end
         n_cmp++; if ({Rs_id, Rt_id, Rd_id} !== m_instr[25:11]) begin n_bad++;
            $display("FAIL rnd_regs #%0d: got %0d/%0d/%0d instr=%h", n, Rs_id, Rt_id, Rd_id, m_instr); end
         n_cmp++; if ({RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id, ALUCode_id} !== c) begin n_bad++;
            $display("FAIL rnd_ctl #%0d: got %b required %b instr=%h", n,
                     {RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id, ALUCode_id}, c, m_instr); end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      Instruction_if = 32'h0; PC = 32'h0;
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      test_reset();
      test_write_through();
      test_load_use();
      test_beq_taken();
      test_jump();
      test_beq_after_alu();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
